// File: rtl/reorder_45_if.sv
// Stream bundle for the 45-point digit-reversed reorder buffer: one input
// stream from the transform core and one natural-order output stream.
interface reorder_45_if #(
  parameter int DW = 16
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_sync;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [5:0]    out_idx;
  logic          out_last;
  logic          sync_err;

  modport slave (
    input  in_data, in_valid, in_sync, out_ready,
    output in_ready, out_data, out_valid, out_idx, out_last, sync_err
  );

  modport master (
    output in_data, in_valid, in_sync, out_ready,
    input  in_ready, out_data, out_valid, out_idx, out_last, sync_err
  );
endinterface

// File: rtl/reorder_45.sv
// Ping-pong reorder buffer: writes (3,3,5) digit-reversed samples to their
// natural address and drains each completed bank in natural order.
module reorder_45 #(
  parameter int DW = 16
) (
  input  logic         clk,
  input  logic         rst,
  reorder_45_if.slave  bus
);

  localparam logic [5:0] last_pos = 6'd44;

  // Natural address of the sample whose digits are (d0,d1,d2): 15*d0 + 5*d1 + d2.
  function automatic logic [5:0] perm_addr(input logic [1:0] d0,
                                           input logic [1:0] d1,
                                           input logic [2:0] d2);
    logic [5:0] a15;
    logic [5:0] a5;
    a15 = {d0, 4'b0000} - {4'b0000, d0};
    a5  = {2'b00, d1, 2'b00} + {4'b0000, d1};
    return a15 + a5 + {3'b000, d2};
  endfunction

  // Stream position of the same digits: d0 + 3*d1 + 9*d2.
  function automatic logic [5:0] stream_pos(input logic [1:0] d0,
                                            input logic [1:0] d1,
                                            input logic [2:0] d2);
    logic [5:0] p3;
    logic [5:0] p9;
    p3 = {3'b000, d1, 1'b0} + {4'b0000, d1};
    p9 = {d2, 3'b000} + {3'b000, d2};
    return {4'b0000, d0} + p3 + p9;
  endfunction

  logic [DW-1:0] mem_r [0:1][0:44];
  logic [1:0]    full_r;
  logic          wr_bank_r;
  logic          rd_bank_r;
  logic [1:0]    d0_r;
  logic [1:0]    d1_r;
  logic [2:0]    d2_r;
  logic [5:0]    rd_cnt_r;
  logic          sync_err_r;

  logic [5:0]    wr_cnt_s;
  logic [5:0]    wr_addr_s;
  logic [5:0]    wr_ptr_s;
  logic          in_ready_s;
  logic          out_valid_s;
  logic          wr_fire_s;
  logic          rd_fire_s;
  logic          wr_done_s;
  logic          rd_done_s;
  logic          resync_s;
  logic [1:0]    d0_nxt_s;
  logic [1:0]    d1_nxt_s;
  logic [2:0]    d2_nxt_s;
  logic [1:0]    full_nxt_s;

  assign wr_cnt_s    = stream_pos(d0_r, d1_r, d2_r);
  assign wr_addr_s   = perm_addr(d0_r, d1_r, d2_r);
  assign in_ready_s  = !full_r[wr_bank_r] && !rst;
  assign out_valid_s = full_r[rd_bank_r] && !rst;
  assign wr_fire_s   = bus.in_valid && in_ready_s;
  assign rd_fire_s   = out_valid_s && bus.out_ready;
  assign wr_done_s   = wr_fire_s && !bus.in_sync && (wr_cnt_s == last_pos);
  assign rd_done_s   = rd_fire_s && (rd_cnt_r == last_pos);
  assign resync_s    = wr_fire_s && bus.in_sync && (wr_cnt_s != 6'd0);
  assign wr_ptr_s    = bus.in_sync ? 6'd0 : wr_addr_s;

  // Next write digits: sync restarts at index 1, frame end clears, else ripple.
  always_comb begin
    d0_nxt_s = d0_r;
    d1_nxt_s = d1_r;
    d2_nxt_s = d2_r;
    if (bus.in_sync) begin
      d0_nxt_s = 2'd1;
      d1_nxt_s = 2'd0;
      d2_nxt_s = 3'd0;
    end else if (wr_cnt_s == last_pos) begin
      d0_nxt_s = 2'd0;
      d1_nxt_s = 2'd0;
      d2_nxt_s = 3'd0;
    end else if (d0_r == 2'd2) begin
      d0_nxt_s = 2'd0;
      if (d1_r == 2'd2) begin
        d1_nxt_s = 2'd0;
        d2_nxt_s = d2_r + 3'd1;
      end else begin
        d1_nxt_s = d1_r + 2'd1;
      end
    end else begin
      d0_nxt_s = d0_r + 2'd1;
    end
  end

  // Bank occupancy: the completing write and read always target different banks.
  always_comb begin
    full_nxt_s = full_r;
    if (wr_done_s) begin
      full_nxt_s[wr_bank_r] = 1'b1;
    end else begin
      full_nxt_s[wr_bank_r] = full_r[wr_bank_r];
    end
    if (rd_done_s) begin
      full_nxt_s[rd_bank_r] = 1'b0;
    end else begin
      full_nxt_s[rd_bank_r] = full_nxt_s[rd_bank_r];
    end
  end

  // Control state: digits, pointers, read counter, occupancy and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      d0_r       <= 2'd0;
      d1_r       <= 2'd0;
      d2_r       <= 3'd0;
      wr_bank_r  <= 1'b0;
      rd_bank_r  <= 1'b0;
      rd_cnt_r   <= 6'd0;
      full_r     <= 2'b00;
      sync_err_r <= 1'b0;
    end else begin
      if (wr_fire_s) begin
        d0_r <= d0_nxt_s;
        d1_r <= d1_nxt_s;
        d2_r <= d2_nxt_s;
      end
      if (wr_done_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
      if (rd_fire_s) begin
        rd_cnt_r <= rd_done_s ? 6'd0 : rd_cnt_r + 6'd1;
      end
      if (rd_done_s) begin
        rd_bank_r <= ~rd_bank_r;
      end
      full_r     <= full_nxt_s;
      sync_err_r <= resync_s;
    end
  end

  // Sample storage is deliberately left unreset; occupancy flags guard it.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_bank_r][wr_ptr_s] <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_valid_s ? mem_r[rd_bank_r][rd_cnt_r] : {DW{1'b0}};
  assign bus.out_idx   = out_valid_s ? rd_cnt_r : 6'd0;
  assign bus.out_last  = out_valid_s && (rd_cnt_r == last_pos);
  assign bus.sync_err  = sync_err_r;

endmodule
